// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the arbiter state enum, owner encoding and default timeout.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 4096;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == OWNER_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-state counter that flags when an access has waited too long.
// Ports: clk_i, rst_i (async high), clr_i, en_i, hit_o (limit reached).
module wb_timeout_counter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CMAX  = '1;

    logic [CW-1:0] cnt;

    // Clear has priority so an ack in a wait cycle restarts the window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != CMAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count holds the number of earlier unacked wait cycles, so hit
    // marks the cycle that would be the last one allowed.
    assign hit_o = (cnt >= LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one Wishbone slave between two masters,
// with burst-long grants and a bounded-wait abort that returns err.
// Ports: clk_i/rst_i; mN_* master sides; s_* slave side; grant_o debug.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [DAT_WIDTH-1:0] m0_dat_i,
    input  logic                 m0_we_i,
    input  logic                 m0_sel_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_addressLength_i,
    output logic [DAT_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [DAT_WIDTH-1:0] m1_dat_i,
    input  logic                 m1_we_i,
    input  logic                 m1_sel_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_addressLength_i,
    output logic [DAT_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [DAT_WIDTH-1:0] s_dat_o,
    output logic                 s_we_o,
    output logic                 s_sel_o,
    output logic                 s_stb_o,
    output logic                 s_cyc_o,
    output logic                 s_addressLength_o,
    input  logic [DAT_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,

    output logic [1:0]           grant_o
);

    arb_state_e state;
    logic       owner;
    logic       last;
    logic       err_q;

    logic [ADR_WIDTH-1:0] own_adr;
    logic [DAT_WIDTH-1:0] own_dat;
    logic own_we;
    logic own_sel;
    logic own_stb;
    logic own_cyc;
    logic own_al;

    logic req_any;
    logic pick;
    logic to_clr;
    logic to_en;
    logic to_hit;

    // Current owner's request, selected once and reused everywhere.
    always_comb begin
        if (owner == OWNER_M1) begin
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
            own_we  = m1_we_i;
            own_sel = m1_sel_i;
            own_stb = m1_stb_i;
            own_cyc = m1_cyc_i;
            own_al  = m1_addressLength_i;
        end else begin
            own_adr = m0_adr_i;
            own_dat = m0_dat_i;
            own_we  = m0_we_i;
            own_sel = m0_sel_i;
            own_stb = m0_stb_i;
            own_cyc = m0_cyc_i;
            own_al  = m0_addressLength_i;
        end
    end

    assign req_any = m0_cyc_i | m1_cyc_i;

    // On a tie the master that did not win last time goes first.
    assign pick = (m0_cyc_i & m1_cyc_i) ? ~last : m1_cyc_i;

    assign to_clr = ((state == IDLE) && req_any) || s_ack_i;
    assign to_en  = (state == BUSY) && own_stb && !s_ack_i;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(to_clr),
        .en_i (to_en),
        .hit_o(to_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= OWNER_M0;
            last  <= OWNER_M1;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        owner <= pick;
                        last  <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                    end else if (own_stb && !s_ack_i && to_hit) begin
                        state <= ABORT;
                        err_q <= 1'b1;
                    end
                end
                ABORT: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_adr_o           = '0;
        s_dat_o           = '0;
        s_we_o            = 1'b0;
        s_sel_o           = 1'b0;
        s_stb_o           = 1'b0;
        s_cyc_o           = 1'b0;
        s_addressLength_o = 1'b0;
        m0_dat_o          = '0;
        m1_dat_o          = '0;
        m0_ack_o          = 1'b0;
        m1_ack_o          = 1'b0;
        unique case (state)
            BUSY: begin
                s_adr_o           = own_adr;
                s_dat_o           = own_dat;
                s_we_o            = own_we;
                s_sel_o           = own_sel;
                s_stb_o           = own_stb;
                s_cyc_o           = own_cyc;
                s_addressLength_o = own_al;
                m0_dat_o          = s_dat_i;
                m1_dat_o          = s_dat_i;
                m0_ack_o          = s_ack_i & (owner == OWNER_M0);
                m1_ack_o          = s_ack_i & (owner == OWNER_M1);
            end
            ABORT: begin
                // Slave sees the cycle dropped; late acks are ignored.
                s_adr_o           = own_adr;
                s_dat_o           = own_dat;
                s_we_o            = own_we;
                s_sel_o           = own_sel;
                s_addressLength_o = own_al;
            end
            default: begin
            end
        endcase
    end

    assign m0_err_o = err_q && (state == ABORT) && (owner == OWNER_M0);
    assign m1_err_o = err_q && (state == ABORT) && (owner == OWNER_M1);

    assign grant_o = (state == IDLE) ? 2'b00 : owner_onehot(owner);

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_wb_arbiter2;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        m_we  [2];
    logic        m_sel [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic        m_al  [2];
    logic [31:0] m_dato [2];
    logic        m_ack [2];
    logic        m_err [2];

    logic [31:0] s_adr_o, s_dat_o, s_dat;
    logic s_we_o, s_sel_o, s_stb_o, s_cyc_o, s_addressLength_o;
    logic s_ack;
    logic [1:0] grant_o;

    wb_arbiter2 #(
        .ADR_WIDTH(32),
        .DAT_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_dat[0]),
        .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]),
        .m0_stb_i(m_stb[0]),
        .m0_cyc_i(m_cyc[0]),
        .m0_addressLength_i(m_al[0]),
        .m0_dat_o(m_dato[0]),
        .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_dat[1]),
        .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]),
        .m1_stb_i(m_stb[1]),
        .m1_cyc_i(m_cyc[1]),
        .m1_addressLength_i(m_al[1]),
        .m1_dat_o(m_dato[1]),
        .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_we_o(s_we_o),
        .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o),
        .s_addressLength_o(s_addressLength_o),
        .s_dat_i(s_dat),
        .s_ack_i(s_ack),
        .grant_o(grant_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model: who holds the bus (-1 = nobody), whether the
    // burst was killed, unacked strobed cycles since the last ack.
    int holder  = -1;
    int last_w  = 1;
    int waited  = 0;
    bit dead    = 1'b0;
    bit err_now = 1'b0;
    bit hang    = 1'b0;

    task automatic check_outputs();
        bit own_v;
        bit live;
        int h;
        logic [1:0] oh;
        own_v = !rst && (holder >= 0);
        h     = (holder > 0) ? 1 : 0;
        live  = own_v && !dead;
        oh    = (h == 1) ? 2'b10 : 2'b01;
        chk("grant", 128'(grant_o), 128'(own_v ? oh : 2'b00));
        chk("s_ctl", 128'({s_cyc_o, s_stb_o}),
            128'(live ? {m_cyc[h], m_stb[h]} : 2'b00));
        chk("ack", 128'({m_ack[1], m_ack[0]}),
            128'((live && s_ack) ? oh : 2'b00));
        chk("err", 128'({m_err[1], m_err[0]}),
            128'((own_v && dead && err_now) ? oh : 2'b00));
        if (!(own_v && dead)) begin
            chk("s_bus",
                128'({s_adr_o, s_dat_o, s_we_o, s_sel_o, s_addressLength_o}),
                live ? 128'({m_adr[h], m_dat[h], m_we[h], m_sel[h], m_al[h]})
                     : 128'(0));
            chk("m0_dat", 128'(m_dato[0]), 128'(live ? s_dat : 32'd0));
            chk("m1_dat", 128'(m_dato[1]), 128'(live ? s_dat : 32'd0));
        end
    endtask

    task automatic model_step();
        int h;
        if (rst) begin
            holder  = -1;
            last_w  = 1;
            waited  = 0;
            dead    = 1'b0;
            err_now = 1'b0;
            return;
        end
        err_now = 1'b0;
        if (holder < 0) begin
            if (m_cyc[0] || m_cyc[1]) begin
                if (m_cyc[0] && m_cyc[1]) holder = 1 - last_w;
                else holder = m_cyc[1] ? 1 : 0;
                last_w = holder;
                waited = 0;
                dead   = 1'b0;
            end
        end else begin
            h = holder;
            if (!m_cyc[h]) begin
                holder = -1;
                dead   = 1'b0;
            end else if (!dead) begin
                if (s_ack) begin
                    waited = 0;
                end else if (m_stb[h]) begin
                    if (waited + 1 == TO) begin
                        dead    = 1'b1;
                        err_now = 1'b1;
                    end else begin
                        waited++;
                    end
                end
            end
        end
    endtask

    // Check mid-cycle, advance the model on the edge, return just after.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_inputs();
        for (int n = 0; n < 2; n++) begin
            if (m_cyc[n]) begin
                if ($urandom_range(15) == 0) m_cyc[n] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                m_cyc[n] = 1'b1;
            end
            m_stb[n] = m_cyc[n] && ($urandom_range(3) != 0);
            m_adr[n] = $urandom;
            m_dat[n] = $urandom;
            m_we[n]  = 1'($urandom_range(1));
            m_sel[n] = 1'($urandom_range(1));
            m_al[n]  = 1'($urandom_range(1));
        end
        if ($urandom_range(19) == 0) hang = !hang;
        s_ack = !hang && ($urandom_range(2) == 0);
        s_dat = $urandom;
        rst   = ($urandom_range(199) == 0);
    endtask

    initial begin
        rst   = 1'b1;
        s_ack = 1'b0;
        s_dat = 32'h0;
        for (int n = 0; n < 2; n++) begin
            m_adr[n] = '0;
            m_dat[n] = '0;
            m_we[n]  = 1'b0;
            m_sel[n] = 1'b0;
            m_stb[n] = 1'b0;
            m_cyc[n] = 1'b0;
            m_al[n]  = 1'b0;
        end
        #1;
        chk("rst_grant", 128'(grant_o), 128'(0));
        chk("rst_cyc", 128'({s_cyc_o, s_stb_o}), 128'(0));
        cycle();
        rst = 1'b0;

        // Tie out of reset goes to m0, then m1, then m0 again.
        m_cyc[0] = 1'b1;
        m_cyc[1] = 1'b1;
        cycle();
        #3 chk("tie_m0", 128'(grant_o), 128'(2'b01));
        m_cyc[0] = 1'b0;
        cycle();
        cycle();
        #3 chk("handoff_m1", 128'(grant_o), 128'(2'b10));
        m_cyc[1] = 1'b0;
        cycle();
        m_cyc[0] = 1'b1;
        m_cyc[1] = 1'b1;
        cycle();
        #3 chk("tie2_m0", 128'(grant_o), 128'(2'b01));

        // m0 write acked after three wait cycles.
        m_stb[0] = 1'b1;
        m_we[0]  = 1'b1;
        m_dat[0] = 32'hA5;
        m_adr[0] = 32'h1000_0000;
        repeat (3) cycle();
        s_ack = 1'b1;
        #3;
        chk("wr_ack0", 128'(m_ack[0]), 128'(1));
        chk("wr_ack1", 128'(m_ack[1]), 128'(0));
        chk("wr_dat", 128'(s_dat_o), 128'(32'hA5));
        cycle();
        s_ack = 1'b0;

        // Slave hangs: eight unacked waits then a one-cycle err.
        repeat (TO) cycle();
        #3;
        chk("to_err", 128'(m_err[0]), 128'(1));
        chk("to_cyc", 128'(s_cyc_o), 128'(0));
        cycle();
        #3;
        chk("to_err_once", 128'(m_err[0]), 128'(0));
        chk("to_hold", 128'(grant_o), 128'(2'b01));
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        cycle();
        cycle();
        #3 chk("to_next_m1", 128'({grant_o, s_cyc_o}), 128'(3'b101));

        // Ack on the last allowed wait cycle beats the timeout.
        m_stb[1] = 1'b1;
        repeat (TO - 1) cycle();
        s_ack = 1'b1;
        #3 chk("edge_ack", 128'(m_ack[1]), 128'(1));
        cycle();
        s_ack = 1'b0;
        m_stb[1] = 1'b0;
        #3;
        chk("edge_noerr", 128'(m_err[1]), 128'(0));
        chk("edge_busy", 128'(s_cyc_o), 128'(1));

        // Burst of four under one m0 cycle while m1 keeps asking.
        m_cyc[1] = 1'b0;
        cycle();
        m_cyc[0] = 1'b1;
        m_cyc[1] = 1'b1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            m_stb[0] = 1'b1;
            m_adr[0] = 32'h1000_0000 + 32'(k);
            m_al[0]  = k[0];
            m_al[1]  = ~k[0];
            cycle();
            s_ack = 1'b1;
            #3;
            chk("burst_al", 128'(s_addressLength_o), 128'(k[0]));
            chk("burst_own", 128'(grant_o), 128'(2'b01));
            cycle();
            s_ack = 1'b0;
            m_stb[0] = 1'b0;
        end
        m_cyc[0] = 1'b0;
        cycle();
        cycle();
        #3 chk("burst_after", 128'(grant_o), 128'(2'b10));

        // Async reset while busy drops the bus immediately.
        m_stb[1] = 1'b1;
        cycle();
        rst = 1'b1;
        #3;
        chk("arst_ctl", 128'({s_cyc_o, s_stb_o}), 128'(0));
        chk("arst_grant", 128'(grant_o), 128'(0));
        cycle();
        rst = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        m_cyc[1] = 1'b1;
        m_adr[1] = 32'h1000_0004;
        cycle();
        #3 chk("arst_m1", 128'({grant_o, s_adr_o}),
               128'({2'b10, 32'h1000_0004}));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
